// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit debounce for the board DIP switches.
// Optional build macro DEBOUNCE_ACTIVE_LOW_EN: pins are active-low and are inverted before debouncing.
module switch_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] s,
    output logic             s_changed,
    output logic             s_valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] in_q_s;
    logic [CW-1:0]    init_cnt_r;
    logic [CW-1:0]    cnt_r [WIDTH];
    logic [WIDTH-1:0] hit_s;
    logic             quiet_s;
    logic             init_done_s;
    logic             load_s;
    logic             run_s;

    // Polarity selection and per-bit threshold detection.
    always_comb begin
`ifdef DEBOUNCE_ACTIVE_LOW_EN
        in_q_s = ~sync2_r;
`else
        in_q_s = sync2_r;
`endif
        quiet_s     = (sync1_r == sync2_r);
        init_done_s = quiet_s && (init_cnt_r == CNT_MAX);
        hit_s       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit_s[i] = (in_q_s[i] != s[i]) && (cnt_r[i] == CNT_MAX);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; RUN is left only through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // FSM output decode.
    always_comb begin
        load_s = 1'b0;
        run_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                load_s = init_done_s;
                run_s  = 1'b0;
            end
            ST_RUN: begin
                load_s = 1'b0;
                run_s  = 1'b1;
            end
            default: begin
                load_s = 1'b0;
                run_s  = 1'b0;
            end
        endcase
    end

    // Synchronizer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            init_cnt_r <= CNT_ZERO;
            s          <= '0;
            s_changed  <= 1'b0;
            s_valid    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r   <= sw_raw;
            sync2_r   <= sync1_r;
            s_changed <= 1'b0;
            if (run_s) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_q_s[i] == s[i] || cnt_r[i] == CNT_MAX) begin
                        cnt_r[i] <= CNT_ZERO;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    end
                end
                s         <= (s & ~hit_s) | (in_q_s & hit_s);
                s_changed <= |hit_s;
            end else if (load_s) begin
                // Initial capture is silent: no change strobe.
                s          <= in_q_s;
                s_valid    <= 1'b1;
                init_cnt_r <= CNT_ZERO;
            end else if (quiet_s) begin
                init_cnt_r <= init_cnt_r + CNT_ONE;
            end else begin
                init_cnt_r <= CNT_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES = 4, using a history-based reference model.
module tb_switch_debouncer;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] s;
    logic       s_changed;
    logic       s_valid;

    int checks   = 0;
    int failures = 0;

    logic [3:0] hist[$];
    logic [3:0] m_s;
    logic       m_chg;
    logic       m_valid;

    switch_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .s(s), .s_changed(s_changed), .s_valid(s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin value sampled at edge n since reset release (0 before edge 1).
    function automatic logic [3:0] raw_at(int n);
        if (n >= 1 && n <= hist.size()) return hist[n-1];
        return 4'd0;
    endfunction

    function automatic logic [3:0] inq_at(int n);
        logic [3:0] v;
        v = raw_at(n - 2);
`ifdef DEBOUNCE_ACTIVE_LOW_EN
        v = ~v;
`endif
        return v;
    endfunction

    // Reference: INIT loads after D consecutive quiet edges; a bit flips once
    // its conditioned level has differed from s and stayed constant for D edges.
    task automatic model_edge(input logic rst, input logic [3:0] raw);
        int k;
        logic ok;
        logic [3:0] flip;
        logic [3:0] cur;
        logic [3:0] past;
        if (rst) begin
            hist.delete();
            m_s = 4'd0; m_chg = 1'b0; m_valid = 1'b0;
        end else begin
            hist.push_back(raw);
            k = hist.size();
            m_chg = 1'b0;
            if (!m_valid) begin
                ok = (k >= D);
                for (int j = k - D + 1; j <= k; j++)
                    if (raw_at(j - 1) != raw_at(j - 2)) ok = 1'b0;
                if (ok) begin
                    m_s = inq_at(k);
                    m_valid = 1'b1;
                end
            end else begin
                flip = 4'd0;
                cur = inq_at(k);
                for (int i = 0; i < 4; i++) begin
                    if (cur[i] != m_s[i]) begin
                        ok = 1'b1;
                        for (int j = k - D + 1; j <= k; j++) begin
                            past = inq_at(j);
                            if (past[i] != cur[i]) ok = 1'b0;
                        end
                        flip[i] = ok;
                    end
                end
                m_s = m_s ^ flip;
                m_chg = |flip;
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, return at next negedge.
    task automatic tick(input logic [3:0] raw, input logic rst);
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        model_edge(rst, raw);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int e = 0; e < 3; e++) tick(4'b1010, 1'b1);
        checks++;
        if ({s, s_changed, s_valid} !== {4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got s=%b chg=%b val=%b want s=0000 chg=0 val=0", s, s_changed, s_valid);
        end
    endtask

    task automatic test_init_capture();
        int pulses = 0;
        for (int e = 1; e <= 8; e++) begin
            tick(4'b1010, 1'b0);
            pulses += int'(s_changed);
            checks++;
            if ({s, s_changed, s_valid} !== {m_s, m_chg, m_valid}) begin
                failures++;
                $display("FAIL init_model edge=%0d got %b/%b/%b want %b/%b/%b", e, s, s_changed, s_valid, m_s, m_chg, m_valid);
            end
            if (e == 5) begin
                checks++;
                if (s_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL init_early edge=5 got val=%b want 0", s_valid);
                end
            end
            if (e == 6) begin
                checks++;
                if ({s, s_valid} !== {4'b1010, 1'b1}) begin
                    failures++;
                    $display("FAIL init_capture edge=6 got s=%b val=%b want 1010/1", s, s_valid);
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL init_no_strobe got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_clean_change();
        for (int e = 1; e <= 8; e++) begin
            tick(4'b1011, 1'b0);
            if (e == 5) begin
                checks++;
                if (s !== 4'b1010) begin
                    failures++;
                    $display("FAIL clean_early edge=5 got s=%b want 1010", s);
                end
            end
            if (e == 6) begin
                checks++;
                if ({s, s_changed} !== {4'b1011, 1'b1}) begin
                    failures++;
                    $display("FAIL clean_update edge=6 got s=%b chg=%b want 1011/1", s, s_changed);
                end
            end
            if (e == 7) begin
                checks++;
                if (s_changed !== 1'b0) begin
                    failures++;
                    $display("FAIL clean_one_cycle edge=7 got chg=%b want 0", s_changed);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        logic saw_high = 1'b0;
        for (int e = 0; e < 11; e++) begin
            tick((e < 3) ? 4'b1111 : 4'b1011, 1'b0);
            pulses += int'(s_changed);
        end
        checks++;
        if (pulses != 0 || s !== 4'b1011) begin
            failures++;
            $display("FAIL glitch_short got pulses=%0d s=%b want 0/1011", pulses, s);
        end
        pulses = 0;
        for (int e = 0; e < 14; e++) begin
            tick((e < 4) ? 4'b1111 : 4'b1011, 1'b0);
            pulses += int'(s_changed);
            if (s[2]) saw_high = 1'b1;
            checks++;
            if ({s, s_changed, s_valid} !== {m_s, m_chg, m_valid}) begin
                failures++;
                $display("FAIL glitch_model step=%0d got %b/%b/%b want %b/%b/%b", e, s, s_changed, s_valid, m_s, m_chg, m_valid);
            end
        end
        checks++;
        if (!saw_high || pulses != 2 || s !== 4'b1011) begin
            failures++;
            $display("FAIL glitch_accept got saw=%b pulses=%0d s=%b want 1/2/1011", saw_high, pulses, s);
        end
    endtask

    task automatic test_bounce();
        for (int e = 1; e <= 20; e++) begin
            tick({1'b0, 2'b01, e[0]}, 1'b0);
            if (e == 5 || e == 6) begin
                checks++;
                if (s[3] !== ((e == 5) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL bounce_bit3 edge=%0d got s=%b", e, s);
                end
            end
            checks++;
            if ({s, s_changed} !== {m_s, m_chg}) begin
                failures++;
                $display("FAIL bounce_model edge=%0d got %b/%b want %b/%b", e, s, s_changed, m_s, m_chg);
            end
        end
        for (int e = 0; e < 6; e++) tick(4'b0011, 1'b0);
        checks++;
        if (s !== 4'b0011) begin
            failures++;
            $display("FAIL bounce_final got s=%b want 0011", s);
        end
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        for (int e = 0; e < 10; e++) begin
            tick(4'b0000, 1'b0);
            pulses += int'(s_changed);
        end
        checks++;
        if (pulses != 1 || s !== 4'b0000) begin
            failures++;
            $display("FAIL simultaneous got pulses=%0d s=%b want 1/0000", pulses, s);
        end
    endtask

    task automatic test_reset_mid();
        for (int e = 0; e < 4; e++) tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b1);
        checks++;
        if ({s, s_changed, s_valid} !== {4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got s=%b chg=%b val=%b want 0000/0/0", s, s_changed, s_valid);
        end
        for (int e = 1; e <= 7; e++) begin
            tick(4'b0010, 1'b0);
            checks++;
            if ({s, s_valid} !== ((e >= 6) ? {4'b0010, 1'b1} : {4'b0000, 1'b0})) begin
                failures++;
                $display("FAIL reset_reinit edge=%0d got s=%b val=%b", e, s, s_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        int hold;
        for (int n = 0; n < 120; n++) begin
            v = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 7);
            for (int h = 0; h < hold; h++) begin
                tick(v, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
                checks++;
                if ({s, s_changed, s_valid} !== {m_s, m_chg, m_valid}) begin
                    failures++;
                    $display("FAIL random_model n=%0d got %b/%b/%b want %b/%b/%b", n, s, s_changed, s_valid, m_s, m_chg, m_valid);
                end
            end
        end
    endtask

    initial begin
        sw_raw = 4'b0000;
        reset  = 1'b1;
        m_s = 4'd0; m_chg = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_init_capture();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input conditioner for the board DIP switches. It synchronizes the raw, asynchronous switch lines into the `clk` domain and debounces each bit independently. It then presents a clean 4-bit `s` bus, with a one-cycle change strobe, to the `leds` and seven-segment logic. It is the input-side counterpart of the `leds` output path: `leds` consumes `s`, and this block produces it.

## Interface
Parameters:
- `WIDTH`, default 4: number of switch bits.
- `DEBOUNCE_CYCLES`, default 480000: consecutive cycles a new level must persist before it is accepted.
  - The default is 10 ms at 48 MHz.
  - Must be ≥ 2.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  raw switch pins; asynchronous, may bounce.
- `s`  out  WIDTH  debounced switch value.
- `s_changed`  out  1  one-cycle pulse on the edge `s` takes a new value in RUN.
- `s_valid`  out  1  high once the initial switch state has been captured.

## Operation
- **Synchronizer:** two flops per bit, `sync1 <= sw_raw`, `sync2 <= sync1`. With `DEBOUNCE_ACTIVE_LOW_EN`, `sync2` is inverted before use; call the result `in_q`.
- **FSM states:** INIT, RUN. Reset enters INIT.
- **INIT:**
  - One shared counter `init_cnt`. On each edge, if the synchronizer is quiet (`sync1 == sync2` on all bits), increment; otherwise clear to 0.
  - When `init_cnt == DEBOUNCE_CYCLES-1` and the synchronizer is quiet: `s <= in_q`, `s_valid <= 1`, go to RUN.
  - No `s_changed` pulse is generated for this load.
- **RUN:** per bit `i`, one counter `cnt[i]`.
  - `in_q[i] == s[i]`: `cnt[i] <= 0`.
  - `in_q[i] != s[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `in_q[i] != s[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `s[i] <= in_q[i]`, `cnt[i] <= 0`.
- **`s_changed`:** registered. It is 1 on exactly the edges where at least one `s` bit updates in RUN, and 0 otherwise. Several bits flipping on the same edge produce a single pulse.
- **Boundaries:**
  - A glitch that reverts before reaching the threshold clears that bit's counter; partial counts never accumulate across glitches.
  - Bits are fully independent; a bouncing bit never delays another.
  - RUN never returns to INIT except via `reset`.
- **Reset:** `reset` high at any edge, including mid-count, forces:
  - `sync1`, `sync2`, `s`, every `cnt`, and `init_cnt` to 0;
  - `s_changed = 0`, `s_valid = 0`, state = INIT.

## Timing
- All outputs are registered; there is no combinational path from `sw_raw` to any output.
- Reset values: `s = 0`, `s_changed = 0`, `s_valid = 0`.
- **RUN latency.** Call the first rising edge that samples a new `sw_raw` level edge 1. Then:
  - `s` updates at edge `DEBOUNCE_CYCLES+2`;
  - `s_changed` is high for the cycle following that edge.
- **Acceptance rule.** A level held for H sampling edges is accepted iff H ≥ `DEBOUNCE_CYCLES`. H = `DEBOUNCE_CYCLES-1` is rejected.
- **INIT timing.** `sw_raw` is constant at a nonzero value A from reset deassertion onward. Count edge 1 as the first edge with `reset` low. Then:
  - `s_valid` rises and `s = A` after edge `DEBOUNCE_CYCLES+2`;
  - if A = 0, they occur after edge `DEBOUNCE_CYCLES`.
- **Throughput.** `s` can change at most once per `DEBOUNCE_CYCLES` cycles per bit.

## Configuration
- `DEBOUNCE_ACTIVE_LOW_EN` defined: switches are active-low (pull-ups), and `in_q = ~sync2`. A switch reading 0 on the pin appears as 1 on `s`.
- Not defined: `in_q = sync2`, so `s` follows pin polarity.
- Reset values of all outputs are unaffected by the macro. In INIT, the synchronizer reset value 0 is treated as a pending change and does not shorten the stability wait.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and no macro unless stated.
- **Init capture:** reset for 3 cycles, release with `sw_raw = 4'b1010` constant → `s_valid` goes 0→1 and `s = 4'b1010` after edge 6; `s_changed` stays 0 throughout.
- **Clean change:** in RUN with `s = 4'b1010`, set `sw_raw = 4'b1011` at edge 1 → `s = 4'b1011` after edge 6; `s_changed` is high for exactly one cycle.
- **Glitch rejection:**
  - Pulse bit 2 high for 3 edges, then return → `s` unchanged and `s_changed` never asserts.
  - Repeat with a 4-edge pulse → `s[2]` goes 1, then back to 0 four edges after the release is seen.
- **Bounce and simultaneous change:**
  - Toggle bit 0 every edge for 20 edges while bit 3 changes cleanly → only bit 3 updates, on schedule.
  - Flip bits 0 and 1 on the same edge → a single `s_changed` pulse.
- **Reset mid-operation:** assert `reset` while `cnt[1] = 2` in RUN → next cycle has `s = 0`, `s_valid = 0`, `s_changed = 0`; after release the INIT timing is repeated exactly.
- **`DEBOUNCE_ACTIVE_LOW_EN` build:** hold `sw_raw = 4'b0101` from reset release → `s = 4'b1010` and `s_valid = 1` after edge 6.
